mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single 128×16 program/data memory between the `reptile` CPU (port A) and a second requester (port B: loader, debug reader or display scanner). Each port uses a level request / one-cycle acknowledge handshake. The arbiter grants one access per cycle using round-robin priority, drives the memory's address, write-data and write-enable, and returns registered read data. It sits between the requesters and the memory array in the top-level wrapper.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_if.sv | 43 ++++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 12;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester handshakes plus the memory-side bus shared by both ports.
interface mem_arb_if #(
  parameter int DATA_W = mem_arb_pkg::DEFAULT_DATA_W,
  parameter int ADDR_W = mem_arb_pkg::DEFAULT_ADDR_W
);

  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Master is the environment: both requesters and the memory array.
  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_rdata,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_rdata,
    output ack_a, rdata_a, ack_b, rdata_b,
    output mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the port that was not
// served last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_t      last,
  output logic       valid,
  output port_t      winner
);

  always_comb begin
    valid  = |eligible;
    winner = PORT_A;
    if (eligible == 2'b11) begin
      winner = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (eligible[1]) begin
      winner = PORT_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between two level-request ports, one access per cycle,
// with registered memory drive and registered read data / ack pulses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  state_t            state;
  port_t             cur;
  port_t             last;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  logic [1:0]        eligible;
  logic              win_valid;
  port_t             win_port;

  // The port currently being served sits out one decision, which is what
  // forces the bubble between back-to-back accesses from a lone requester.
  always_comb begin
    eligible = {bus.req_b, bus.req_a};
    if (state == ST_SERVE) begin
      if (cur == PORT_A) eligible[0] = 1'b0;
      else               eligible[1] = 1'b0;
    end
  end

  rr_arbiter2 u_rr (
    .eligible (eligible),
    .last     (last),
    .valid    (win_valid),
    .winner   (win_port)
  );

  // Captured request fields live directly in the mem_* registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur       <= PORT_A;
      last      <= PORT_B;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (state == ST_SERVE) begin
        if (cur == PORT_A) begin
          ack_a <= 1'b1;
          if (!mem_we) rdata_a <= bus.mem_rdata;
        end else begin
          ack_b <= 1'b1;
          if (!mem_we) rdata_b <= bus.mem_rdata;
        end
      end

      if (win_valid) begin
        state <= ST_SERVE;
        cur   <= win_port;
        last  <= win_port;
        if (win_port == PORT_A) begin
          mem_we    <= bus.we_a;
          mem_addr  <= bus.addr_a;
          mem_wdata <= bus.wdata_a;
        end else begin
          mem_we    <= bus.we_b;
          mem_addr  <= bus.addr_b;
          mem_wdata <= bus.wdata_b;
        end
      end else begin
        state  <= ST_IDLE;
        mem_we <= 1'b0;
      end
    end
  end

  assign bus.ack_a     = ack_a;
  assign bus.ack_b     = ack_b;
  assign bus.rdata_a   = rdata_a;
  assign bus.rdata_b   = rdata_b;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural 128-word memory plus a
// per-port scoreboard of expected completions popped on every ack.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a;
  exp_t        e_b;
  logic [15:0] exp_ra;
  logic [15:0] exp_rb;
  logic [15:0] mem [128];

  mem_arb_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[6:0]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[6:0]] = bus.mem_wdata;
  end

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i * 37);
    return 16'hA500 ^ v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input port_t p, input logic req, input logic we,
                                input logic [11:0] addr, input logic [15:0] wdata);
    if (p == PORT_A) begin
      bus.req_a = req; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
    end else begin
      bus.req_b = req; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
    end
  endtask

  task automatic push_exp(input port_t p, input logic is_read, input logic [15:0] data);
    exp_t e;
    e.is_read = is_read;
    e.data    = data;
    if (p == PORT_A) q_a.push_back(e);
    else             q_b.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every ack must match the oldest outstanding access of that port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack_a) begin
        if (q_a.size() == 0) begin
          check_output("ack_a_spurious", {31'b0, bus.ack_a}, 32'd0);
        end else begin
          e_a = q_a.pop_front();
          if (e_a.is_read) exp_ra = e_a.data;
          check_output("rdata_a", {16'b0, bus.rdata_a}, {16'b0, exp_ra});
        end
        if (!bus.ack_b) check_output("rdata_b_hold", {16'b0, bus.rdata_b}, {16'b0, exp_rb});
      end
      if (bus.ack_b) begin
        if (q_b.size() == 0) begin
          check_output("ack_b_spurious", {31'b0, bus.ack_b}, 32'd0);
        end else begin
          e_b = q_b.pop_front();
          if (e_b.is_read) exp_rb = e_b.data;
          check_output("rdata_b", {16'b0, bus.rdata_b}, {16'b0, exp_rb});
        end
        if (!bus.ack_a) check_output("rdata_a_hold", {16'b0, bus.rdata_a}, {16'b0, exp_ra});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_ra     = '0;
    exp_rb     = '0;
    rst_n      = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = pat(i);
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    apply_stimulus(PORT_B, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(2);

    check_output("rst_ack_a",     {31'b0, bus.ack_a},     32'd0);
    check_output("rst_ack_b",     {31'b0, bus.ack_b},     32'd0);
    check_output("rst_rdata_a",   {16'b0, bus.rdata_a},   32'd0);
    check_output("rst_rdata_b",   {16'b0, bus.rdata_b},   32'd0);
    check_output("rst_mem_we",    {31'b0, bus.mem_we},    32'd0);
    check_output("rst_mem_addr",  {20'b0, bus.mem_addr},  32'd0);
    check_output("rst_mem_wdata", {16'b0, bus.mem_wdata}, 32'd0);

    // Tie straight out of reset: A first, then B.
    rst_n = 1'b1;
    apply_stimulus(PORT_A, 1'b1, 1'b0, 12'h020, 16'h0000); push_exp(PORT_A, 1'b1, pat(32));
    apply_stimulus(PORT_B, 1'b1, 1'b0, 12'h021, 16'h0000); push_exp(PORT_B, 1'b1, pat(33));
    step(1);
    check_output("tie_serve_a_addr", {20'b0, bus.mem_addr}, 32'h020);
    check_output("tie_serve_a_we",   {31'b0, bus.mem_we},   32'd0);
    step(1);
    check_output("tie_serve_b_addr", {20'b0, bus.mem_addr}, 32'h021);
    check_output("tie_ack_a_c2",     {31'b0, bus.ack_a},    32'd1);
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(1);
    check_output("tie_ack_b_c3",     {31'b0, bus.ack_b},    32'd1);
    check_output("tie_no_ack_a_c3",  {31'b0, bus.ack_a},    32'd0);
    apply_stimulus(PORT_B, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(2);

    // A writes then reads back the same word.
    apply_stimulus(PORT_A, 1'b1, 1'b1, 12'h005, 16'hBEEF); push_exp(PORT_A, 1'b0, 16'h0000);
    step(1);
    check_output("wr_a_we",    {31'b0, bus.mem_we},    32'd1);
    check_output("wr_a_addr",  {20'b0, bus.mem_addr},  32'h005);
    check_output("wr_a_wdata", {16'b0, bus.mem_wdata}, 32'hBEEF);
    step(1);
    check_output("wr_a_ack",   {31'b0, bus.ack_a},     32'd1);
    check_output("wr_a_we_one_cycle", {31'b0, bus.mem_we}, 32'd0);
    apply_stimulus(PORT_A, 1'b1, 1'b0, 12'h005, 16'h0000); push_exp(PORT_A, 1'b1, 16'hBEEF);
    step(1);
    check_output("rd_a_addr",  {20'b0, bus.mem_addr},  32'h005);
    check_output("rd_a_no_we", {31'b0, bus.mem_we},    32'd0);
    step(1);
    check_output("rd_a_ack",   {31'b0, bus.ack_a},     32'd1);
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(2);

    // A alone holding req: serve every other cycle.
    apply_stimulus(PORT_A, 1'b1, 1'b1, 12'h030, 16'h1111);
    for (int k = 0; k < 3; k++) push_exp(PORT_A, 1'b0, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check_output($sformatf("solo_we_c%0d", k),  {31'b0, bus.mem_we}, {31'b0, (k % 2 == 1)});
      check_output($sformatf("solo_ack_c%0d", k), {31'b0, bus.ack_a},  {31'b0, (k % 2 == 0)});
    end
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(1);
    check_output("solo_quiet_ack", {31'b0, bus.ack_a}, 32'd0);
    step(1);

    // Both holding: last served was A, so B leads and they alternate.
    apply_stimulus(PORT_A, 1'b1, 1'b1, 12'h040, 16'hAAAA);
    apply_stimulus(PORT_B, 1'b1, 1'b1, 12'h041, 16'hBBBB);
    for (int k = 0; k < 2; k++) begin
      push_exp(PORT_A, 1'b0, 16'h0000);
      push_exp(PORT_B, 1'b0, 16'h0000);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check_output($sformatf("alt_addr_c%0d", k), {20'b0, bus.mem_addr},
                   (k % 2 == 1) ? 32'h041 : 32'h040);
      check_output($sformatf("alt_we_c%0d", k), {31'b0, bus.mem_we}, 32'd1);
    end
    apply_stimulus(PORT_B, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(1);
    check_output("alt_end_we",  {31'b0, bus.mem_we}, 32'd0);
    check_output("alt_end_ack", {31'b0, bus.ack_a},  32'd1);
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(2);

    // B writes, A reads it back; rdata_b keeps its earlier read value.
    apply_stimulus(PORT_B, 1'b1, 1'b1, 12'h010, 16'h00FF); push_exp(PORT_B, 1'b0, 16'h0000);
    step(1);
    check_output("wr_b_we",   {31'b0, bus.mem_we},   32'd1);
    check_output("wr_b_addr", {20'b0, bus.mem_addr}, 32'h010);
    step(1);
    check_output("wr_b_ack",  {31'b0, bus.ack_b},    32'd1);
    apply_stimulus(PORT_B, 1'b0, 1'b0, 12'h000, 16'h0000);
    apply_stimulus(PORT_A, 1'b1, 1'b0, 12'h010, 16'h0000); push_exp(PORT_A, 1'b1, 16'h00FF);
    step(1);
    check_output("rd_a010_addr", {20'b0, bus.mem_addr}, 32'h010);
    step(1);
    check_output("rd_a010_rdata",  {16'b0, bus.rdata_a}, 32'h00FF);
    check_output("rd_a010_rdata_b", {16'b0, bus.rdata_b}, {16'b0, pat(33)});
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(2);

    // Reset lands inside B's write SERVE cycle: write and ack are dropped.
    apply_stimulus(PORT_B, 1'b1, 1'b1, 12'h007, 16'h1234); push_exp(PORT_B, 1'b0, 16'h0000);
    step(1);
    check_output("abort_we_before", {31'b0, bus.mem_we},   32'd1);
    check_output("abort_addr",      {20'b0, bus.mem_addr}, 32'h007);
    #2;
    rst_n = 1'b0;
    q_b.delete();
    exp_ra = '0;
    exp_rb = '0;
    #1;
    check_output("abort_we_now",    {31'b0, bus.mem_we},    32'd0);
    check_output("abort_addr_rst",  {20'b0, bus.mem_addr},  32'd0);
    check_output("abort_wdata_rst", {16'b0, bus.mem_wdata}, 32'd0);
    check_output("abort_rdata_b",   {16'b0, bus.rdata_b},   32'd0);
    apply_stimulus(PORT_B, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(1);
    check_output("abort_no_ack_b",  {31'b0, bus.ack_b},     32'd0);
    check_output("abort_mem7",      {16'b0, mem[7]},        {16'b0, pat(7)});
    rst_n = 1'b1;
    apply_stimulus(PORT_A, 1'b1, 1'b0, 12'h050, 16'h0000); push_exp(PORT_A, 1'b1, pat(80));
    apply_stimulus(PORT_B, 1'b1, 1'b0, 12'h051, 16'h0000); push_exp(PORT_B, 1'b1, pat(81));
    step(1);
    check_output("post_rst_tie_a", {20'b0, bus.mem_addr}, 32'h050);
    step(1);
    check_output("post_rst_b",     {20'b0, bus.mem_addr}, 32'h051);
    check_output("post_rst_ack_a", {31'b0, bus.ack_a},    32'd1);
    apply_stimulus(PORT_A, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(1);
    check_output("post_rst_ack_b", {31'b0, bus.ack_b},    32'd1);
    apply_stimulus(PORT_B, 1'b0, 1'b0, 12'h000, 16'h0000);
    step(2);

    check_output("drain_q_a", q_a.size(), 32'd0);
    check_output("drain_q_b", q_b.size(), 32'd0);
    check_output("mem_005", {16'b0, mem[5]},     32'hBEEF);
    check_output("mem_010", {16'b0, mem[16]},    32'h00FF);
    check_output("mem_030", {16'b0, mem[48]},    32'h1111);
    check_output("mem_040", {16'b0, mem[64]},    32'hAAAA);
    check_output("mem_041", {16'b0, mem[65]},    32'hBBBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
